// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states, default widths and the generator period.
package pwm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DUTY_W_DEF = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_div.sv
// Restoring divider producing one quotient bit per cycle; the upper part of the
// dividend must already be smaller than the divisor so the quotient fits DUTY_W bits.
module pwm_div import pwm_pkg::*; #(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W+DUTY_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  output logic                    busy,
  output logic                    done,
  output logic [DUTY_W-1:0]       quotient
);

  localparam int IW = $clog2(DUTY_W + 1);

  logic              run;
  logic [IW-1:0]     iter;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvs;
  logic [DUTY_W-1:0] low;
  logic [DUTY_W-1:0] quo;
  logic [CNT_W:0]    shifted;
  logic [CNT_W-1:0]  diff;
  logic              ge;

  // The partial remainder is always below the divisor, so rem*2+bit fits CNT_W+1 bits
  // and the subtraction result fits CNT_W bits.
  always_comb begin
    shifted = {rem, low[DUTY_W-1]};
    diff    = shifted[CNT_W-1:0] - dvs;
    ge      = (shifted >= {1'b0, dvs});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      done <= 1'b0;
      iter <= '0;
      rem  <= '0;
      dvs  <= '0;
      low  <= '0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run  <= 1'b0;
        iter <= '0;
      end else if (start) begin
        rem  <= dividend[CNT_W+DUTY_W-1:DUTY_W];
        low  <= dividend[DUTY_W-1:0];
        dvs  <= divisor;
        quo  <= '0;
        iter <= '0;
        run  <= 1'b1;
      end else if (run) begin
        rem  <= ge ? diff : shifted[CNT_W-1:0];
        low  <= low << 1;
        quo  <= (quo << 1) | DUTY_W'(ge);
        iter <= iter + 1'b1;
        if (iter == IW'(DUTY_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // The done cycle counts as busy so a result is never overwritten before it is taken.
  assign busy     = run | done;
  assign quotient = quo;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period/high time of pwm_in and reports duty = high*2^DUTY_W/period.
// Define PWM_CAPTURE_DEGLITCH_EN to add a 2-sample majority filter behind the synchronizer.
module pwm_capture import pwm_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              overrun
);

  logic              sync1, sync2, level, prev;
  logic              rise, fall;
  state_t            state;
  logic [CNT_W-1:0]  per_cnt, hi_cnt, idle_cnt;
  logic [CNT_W-1:0]  op_period, op_high;
  logic              timeout_hit, div_start, div_abort;
  logic              div_busy, div_done;
  logic [DUTY_W-1:0] quotient;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic sync3, filt;

  // The filtered level only follows two consecutive equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync3 <= 1'b0;
      filt  <= 1'b0;
    end else begin
      sync3 <= sync2;
      if (sync2 == sync3) filt <= sync2;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

  // An edge in the same cycle always beats the timeout.
  always_comb begin
    timeout_hit = !(rise || fall) && (idle_cnt == CNT_W'(TIMEOUT - 1));
    div_start   = (state == MEAS_LOW) && rise && !div_busy;
    div_abort   = timeout_hit;
  end

  pwm_div #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend ({hi_cnt, {DUTY_W{1'b0}}}),
    .divisor  (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // Counters restart at 1 on a rise because the edge cycle itself belongs to the new period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_RISE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      idle_cnt  <= '0;
      op_period <= '0;
      op_high   <= '0;
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (rise || fall)                      idle_cnt <= '0;
      else if (idle_cnt != CNT_W'(TIMEOUT))  idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit) begin
        period    <= '0;
        high_time <= '0;
        duty      <= {DUTY_W{level}};
        valid     <= 1'b1;
        stuck     <= 1'b1;
        state     <= WAIT_RISE;
      end else begin
        if (div_done) begin
          period    <= op_period;
          high_time <= op_high;
          duty      <= quotient;
          valid     <= 1'b1;
        end
        if (rise) stuck <= 1'b0;

        case (state)
          WAIT_RISE: begin
            if (rise) begin
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
              state   <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            per_cnt <= per_cnt + 1'b1;
            if (fall) state  <= MEAS_LOW;
            else      hi_cnt <= hi_cnt + 1'b1;
          end
          MEAS_LOW: begin
            if (rise) begin
              if (div_busy) begin
                overrun <= 1'b1;
              end else begin
                op_period <= per_cnt;
                op_high   <= hi_cnt;
              end
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
              state   <= MEAS_HIGH;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          default: state <= WAIT_RISE;
        endcase
      end
    end
  end

endmodule
